// File: rtl/cpu_types_pkg.sv
// Shared CPU types: cache address split, instruction cache frame and controller state.
package cpu_types_pkg;

  localparam int unsigned ITAG_W = 26;
  localparam int unsigned IIDX_W = 4;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame;

  typedef enum logic {IC_IDLE, IC_FETCH} icache_state_t;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache with same-cycle hits, blocking
// single-word miss fill, synchronous flush and saturating hit/miss counters.
module icache_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned TAG_W = ITAG_W,
  parameter int unsigned IDX_W = IIDX_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic [31:0]      imemload,
  output logic             ihit,
  input  logic             iflush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic [31:0]      iload,
  input  logic             iwait,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned NFRAMES = 1 << IDX_W;

  icache_state_t    state_q, state_d;
  icachef_t         miss_addr_q, miss_addr_d;
  icache_frame      frame_q [NFRAMES];
  icache_frame      frame_d [NFRAMES];
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  icache_frame      sel;
  logic             hit;
  logic             miss;
  logic             unused_bytoff;

  // Byte offset plays no part in lookup or fill.
  assign unused_bytoff = ^imemaddr[1:0];

  always_comb begin
    req_idx = imemaddr[IDX_W+1:2];
    req_tag = imemaddr[31 -: TAG_W];
    sel     = frame_q[req_idx];
    hit     = imemREN && sel.valid && (sel.tag == req_tag) && (state_q == IC_IDLE);
    miss    = imemREN && !hit && (state_q == IC_IDLE);
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    frame_d     = frame_q;
    iREN        = 1'b0;
    case (state_q)
      IC_IDLE: begin
        if (miss) begin
          miss_addr_d = icachef_t'({imemaddr[31:2], 2'b00});
          state_d     = IC_FETCH;
        end
      end
      IC_FETCH: begin
        // Fill always completes for the latched address, even if the PC moved.
        iREN = 1'b1;
        if (!iwait) begin
          frame_d[miss_addr_q.idx] = '{valid: 1'b1, tag: miss_addr_q.tag, data: iload};
          state_d                  = IC_IDLE;
        end
      end
    endcase
    // Flush is applied last so it beats a fill landing on the same edge.
    if (iflush) begin
      for (int unsigned i = 0; i < NFRAMES; i++) begin
        frame_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    hit_cnt_d  = (hit && (hit_cnt_q != '1)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
    miss_cnt_d = (miss && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IC_IDLE;
      miss_addr_q <= '0;
      for (int unsigned i = 0; i < NFRAMES; i++) begin
        frame_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      frame_q     <= frame_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign ihit       = hit;
  assign imemload   = hit ? sel.data : '0;
  assign iaddr      = miss_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus random traffic, compared
// cycle by cycle against an address-level cache model.
module tb_icache_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 CLK = ~CLK;

  icache_ctrl #(.TAG_W(26), .IDX_W(4), .CNT_W(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .imemload   (imemload),
    .ihit       (ihit),
    .iflush     (iflush),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: each slot remembers which word address it holds.
  bit          m_vld  [16];
  logic [31:0] m_line [16];
  logic [31:0] m_data [16];
  bit          m_busy;
  logic [31:0] m_pend;
  int unsigned m_hits;
  int unsigned m_misses;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_vld[i]  = 1'b0;
      m_line[i] = '0;
      m_data[i] = '0;
    end
    m_busy   = 1'b0;
    m_pend   = '0;
    m_hits   = 0;
    m_misses = 0;
  endfunction

  task automatic step(input logic ren, input logic [31:0] addr, input logic fl,
                      input logic wt, input logic [31:0] ld);
    logic [31:0] line;
    int unsigned slot;
    bit          exp_hit;
    @(negedge CLK);
    imemREN  = ren;
    imemaddr = addr;
    iflush   = fl;
    iwait    = wt;
    iload    = ld;
    #1;
    line    = addr & 32'hFFFF_FFFC;
    slot    = (addr >> 2) % 16;
    exp_hit = ren && !m_busy && m_vld[slot] && (m_line[slot] == line);
    check_eq("ihit", {31'b0, ihit}, {31'b0, exp_hit});
    check_eq("imemload", imemload, exp_hit ? m_data[slot] : 32'h0);
    check_eq("iREN", {31'b0, iREN}, {31'b0, m_busy});
    check_eq("iaddr", iaddr, m_pend);
    check_eq("hit_count", hit_count, m_hits);
    check_eq("miss_count", miss_count, m_misses);
    if (m_busy && !wt) begin
      m_vld[(m_pend >> 2) % 16]  = 1'b1;
      m_line[(m_pend >> 2) % 16] = m_pend;
      m_data[(m_pend >> 2) % 16] = ld;
      m_busy = 1'b0;
    end else if (!m_busy && ren && !exp_hit) begin
      m_busy = 1'b1;
      m_pend = line;
      m_misses++;
    end
    if (exp_hit) m_hits++;
    if (fl) begin
      for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    end
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iflush   = 1'b0;
    iwait    = 1'b0;
    iload    = 32'h1234_5678;
    model_reset();
    @(negedge CLK);
    #1;
    check_eq("rst_ihit", {31'b0, ihit}, 32'h0);
    check_eq("rst_imemload", imemload, 32'h0);
    check_eq("rst_iREN", {31'b0, iREN}, 32'h0);
    check_eq("rst_iaddr", iaddr, 32'h0);
    check_eq("rst_hits", hit_count, 32'h0);
    check_eq("rst_misses", miss_count, 32'h0);
    imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Cold miss, memory busy for 3 cycles
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'hDEAD_BEEF);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("t1_hit", {31'b0, ihit}, 32'h1);
    check_eq("t1_load", imemload, 32'hDEAD_BEEF);
    check_eq("t1_misses", miss_count, 32'h1);

    // Repeat hit: ten hit cycles in total
    for (int i = 0; i < 9; i++) step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    step(1'b0, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("t2_hits", hit_count, 32'd10);

    // Conflict on index 0
    step(1'b1, 32'h440, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h440, 1'b0, 1'b0, 32'h1111_1111);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'hCAFE_0040);
    check_eq("t3_misses", miss_count, 32'd3);

    // Address change while the fill is outstanding
    step(1'b1, 32'h80, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    check_eq("t4_iaddr_held", iaddr, 32'h80);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'hAAAA_0080);
    step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    check_eq("t4_iaddr_new", iaddr, 32'h100);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'hBBBB_0100);

    // Flush coinciding with fill completion
    step(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h44, 1'b0, 1'b0, 32'h4444_4444);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h40, 1'b1, 1'b0, 32'h5555_5555);
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("t5_flush_miss", {31'b0, ihit}, 32'h0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 32'h6666_6666);
    step(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
    check_eq("t5_other_miss", {31'b0, ihit}, 32'h0);
    step(1'b1, 32'h44, 1'b0, 1'b0, 32'h7777_7777);

    // Asynchronous reset in the middle of a fetch
    step(1'b1, 32'h80, 1'b0, 1'b1, 32'h0);
    step(1'b1, 32'h80, 1'b0, 1'b1, 32'h0);
    #2;
    RST     = 1'b1;
    imemREN = 1'b0;
    #1;
    check_eq("t6_iREN", {31'b0, iREN}, 32'h0);
    check_eq("t6_ihit", {31'b0, ihit}, 32'h0);
    check_eq("t6_hits", hit_count, 32'h0);
    check_eq("t6_misses", miss_count, 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    step(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    check_eq("t6_invalid", {31'b0, ihit}, 32'h0);

    // Random traffic over a small address set to force hits and conflicts
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) << 10) | ($urandom_range(0, 1) << 25)
        | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 7) != 0, a, $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
